// File: rtl/uart16550_pkg.sv
// Shared definitions for the 16550 UART transmit/receive datapath.
//   TX_FIFO_DEPTH : default depth of the TX FIFO
//   TX_LVL_W      : width of a fill-level value (0..TX_FIFO_DEPTH)
//   tx_level_t    : fill-level type for the default-depth TX FIFO
package uart16550_pkg;

   localparam int TX_FIFO_DEPTH = 16;
   localparam int TX_LVL_W      = $clog2(TX_FIFO_DEPTH) + 1;

   typedef logic [TX_LVL_W-1:0] tx_level_t;

endpackage

// File: rtl/uart16550_fifo.sv
// Generic circular-buffer FIFO used by the UART TX and RX paths.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr           : synchronous clear of pointers and count (wins over wr/rd)
//   wr, din       : push request and data
//   rd            : pop request (ignored while empty)
//   dout          : head entry, combinational from mem[rd_ptr]
//   count         : current fill level; count_nxt is the level after this edge
//   full, empty   : status flags
// A push while full is accepted only if a pop is accepted in the same cycle.
module uart16550_fifo #(
   parameter  int DEPTH = 16,
   parameter  int DW    = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk_i,
   input  logic          rst_ni,
   input  logic          clr,
   input  logic          wr,
   input  logic [DW-1:0] din,
   input  logic          rd,
   output logic [DW-1:0] dout,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_nxt,
   output logic          full,
   output logic          empty
);

   logic [DW-1:0] mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          rd_ok;
   logic          wr_ok;

   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);
   assign dout  = mem[rd_ptr];

   assign rd_ok = rd & ~empty & ~clr;
   assign wr_ok = wr & (~full | rd_ok) & ~clr;

   always_comb begin
      count_nxt = count;
      if (clr) begin
         count_nxt = '0;
      end else begin
         case ({wr_ok, rd_ok})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nxt;
         if (clr) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (rd_ok) rd_ptr <= rd_ptr + AW'(1);
            if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
         end
      end
   end

   // Storage is reset so the head output is a defined 0 out of reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

endmodule

// File: rtl/uart16550_tx_ctrl.sv
// Transmit-side controller of the 16550 UART: owns the THR / TX FIFO,
// gates transmitter starts and produces LSR THRE/TEMT and THRE interrupt.
// Optional macro UART16550_AUTO_CTS_EN adds automatic CTS flow control.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   thr_we_i/thr_d_i : THR write strobe and data
//   fifo_en_i      : FCR[0], 0 = single-byte holding register
//   tx_fifo_rst_i  : FCR[2] pulse, clears the TX FIFO
//   etbei_i        : IER THRE interrupt enable
//   iir_rd_thre_i  : IIR read while THRE is the reported source
//   pop_i          : transmitter consumed the head byte
//   sr_empty_i     : transmitter shift register empty
//   cts_ni, afe_i  : (macro only) modem CTS_n and MCR auto-flow enable
//   tx_thre_o      : 1 = transmitter may not start a character
//   d_o            : head byte
//   lsr_thre_o, lsr_temt_o : LSR[5], LSR[6]
//   thre_ip_o      : THRE interrupt pending
//   level_o        : TX FIFO fill level
module uart16550_tx_ctrl
   import uart16550_pkg::*;
#(
   parameter  int DEPTH = TX_FIFO_DEPTH,
   parameter  int DW    = 8,
   localparam int LW    = $clog2(DEPTH) + 1
) (
   input  logic          rst_ni,
   input  logic          clk_i,
   input  logic          thr_we_i,
   input  logic [DW-1:0] thr_d_i,
   input  logic          fifo_en_i,
   input  logic          tx_fifo_rst_i,
   input  logic          etbei_i,
   input  logic          iir_rd_thre_i,
   input  logic          pop_i,
   input  logic          sr_empty_i,
`ifdef UART16550_AUTO_CTS_EN
   input  logic          cts_ni,
   input  logic          afe_i,
`endif
   output logic          tx_thre_o,
   output logic [DW-1:0] d_o,
   output logic          lsr_thre_o,
   output logic          lsr_temt_o,
   output logic          thre_ip_o,
   output logic [LW-1:0] level_o
);

   logic          en_q;
   logic          etbei_q;
   logic          empty_q;
   logic          ip_q;
   logic          ip_d;
   logic          clr;
   logic [LW-1:0] cap;
   logic [LW-1:0] count;
   logic [LW-1:0] count_nxt;
   logic          full;
   logic          empty;
   logic          pop_acc;
   logic          wr_acc;
   logic          ip_set;
   logic          ip_clr;

   // A change of FIFO mode flushes the FIFO, same as an FCR[2] write.
   assign clr = tx_fifo_rst_i | (fifo_en_i ^ en_q);
   assign cap = fifo_en_i ? LW'(DEPTH) : LW'(1);

   assign pop_acc = pop_i & ~empty & ~clr;
   // At capacity a write still lands if the head leaves in the same cycle.
   assign wr_acc  = thr_we_i & ~clr & (((count < cap) & ~full) | pop_acc);

   uart16550_fifo #(
      .DEPTH (DEPTH),
      .DW    (DW)
   ) u_fifo (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clr       (clr),
      .wr        (wr_acc),
      .din       (thr_d_i),
      .rd        (pop_acc),
      .dout      (d_o),
      .count     (count),
      .count_nxt (count_nxt),
      .full      (full),
      .empty     (empty)
   );

   assign ip_set = ((count == LW'(1)) & (count_nxt == '0)) | (~etbei_q & empty);
   assign ip_clr = wr_acc | iir_rd_thre_i;

   always_comb begin
      ip_d = ip_q;
      if (!etbei_i)    ip_d = 1'b0;
      else if (ip_clr) ip_d = 1'b0;
      else if (ip_set) ip_d = 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         en_q    <= 1'b0;
         etbei_q <= 1'b0;
         empty_q <= 1'b1;
         ip_q    <= 1'b0;
      end else begin
         en_q    <= fifo_en_i;
         etbei_q <= etbei_i;
         empty_q <= (count_nxt == '0);
         ip_q    <= ip_d;
      end
   end

`ifdef UART16550_AUTO_CTS_EN
   logic cts_meta_n;
   logic cts_sync_n;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cts_meta_n <= 1'b1;
         cts_sync_n <= 1'b1;
      end else begin
         cts_meta_n <= cts_ni;
         cts_sync_n <= cts_meta_n;
      end
   end

   // Only new starts are held; a character in flight is not affected.
   assign tx_thre_o = empty_q | (afe_i & cts_sync_n);
`else
   assign tx_thre_o = empty_q;
`endif

   assign lsr_thre_o = empty;
   assign lsr_temt_o = empty & sr_empty_i;
   assign thre_ip_o  = ip_q & etbei_i;
   assign level_o    = count;

endmodule

// File: tb/tb_uart16550_tx_ctrl.sv
module tb_uart16550_tx_ctrl;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       thr_we_i;
   logic [7:0] thr_d_i;
   logic       fifo_en_i;
   logic       tx_fifo_rst_i;
   logic       etbei_i;
   logic       iir_rd_thre_i;
   logic       pop_i;
   logic       sr_empty_i;
   logic       tx_thre_o;
   logic [7:0] d_o;
   logic       lsr_thre_o;
   logic       lsr_temt_o;
   logic       thre_ip_o;
   logic [4:0] level_o;
`ifdef UART16550_AUTO_CTS_EN
   logic       cts_ni;
   logic       afe_i;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk_i = ~clk_i;

   uart16550_tx_ctrl #(.DEPTH(16), .DW(8)) dut (
      .rst_ni        (rst_ni),
      .clk_i         (clk_i),
      .thr_we_i      (thr_we_i),
      .thr_d_i       (thr_d_i),
      .fifo_en_i     (fifo_en_i),
      .tx_fifo_rst_i (tx_fifo_rst_i),
      .etbei_i       (etbei_i),
      .iir_rd_thre_i (iir_rd_thre_i),
      .pop_i         (pop_i),
      .sr_empty_i    (sr_empty_i),
`ifdef UART16550_AUTO_CTS_EN
      .cts_ni        (cts_ni),
      .afe_i         (afe_i),
`endif
      .tx_thre_o     (tx_thre_o),
      .d_o           (d_o),
      .lsr_thre_o    (lsr_thre_o),
      .lsr_temt_o    (lsr_temt_o),
      .thre_ip_o     (thre_ip_o),
      .level_o       (level_o)
   );

   // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic wr_byte(input logic [7:0] b);
      thr_we_i = 1'b1;
      thr_d_i  = b;
      step();
      thr_we_i = 1'b0;
   endtask

   task automatic pop_byte();
      pop_i = 1'b1;
      step();
      pop_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      thr_we_i = 0; thr_d_i = 0; fifo_en_i = 0; tx_fifo_rst_i = 0;
      etbei_i = 0; iir_rd_thre_i = 0; pop_i = 0; sr_empty_i = 1;
`ifdef UART16550_AUTO_CTS_EN
      cts_ni = 1; afe_i = 0;
`endif
      step(); step();
      rst_ni = 1'b1;
      step();
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL reset_level got=%0d exp=0", level_o); end
      checks++; if (lsr_thre_o !== 1'b1) begin errors++; $display("FAIL reset_lsr_thre got=%b exp=1", lsr_thre_o); end
      checks++; if (tx_thre_o !== 1'b1) begin errors++; $display("FAIL reset_tx_thre got=%b exp=1", tx_thre_o); end
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL reset_thre_ip got=%b exp=0", thre_ip_o); end
      checks++; if (lsr_temt_o !== 1'b1) begin errors++; $display("FAIL reset_temt got=%b exp=1", lsr_temt_o); end
      checks++; if (d_o !== 8'h00) begin errors++; $display("FAIL reset_d got=%h exp=00", d_o); end
   endtask

   task automatic test_holding();
      wr_byte(8'hA5);
      checks++; if (tx_thre_o !== 1'b0) begin errors++; $display("FAIL hold_tx_thre got=%b exp=0", tx_thre_o); end
      checks++; if (d_o !== 8'hA5) begin errors++; $display("FAIL hold_d got=%h exp=a5", d_o); end
      checks++; if (lsr_thre_o !== 1'b0) begin errors++; $display("FAIL hold_lsr_thre got=%b exp=0", lsr_thre_o); end
      wr_byte(8'h3C);
      checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL hold_drop_level got=%0d exp=1", level_o); end
      checks++; if (d_o !== 8'hA5) begin errors++; $display("FAIL hold_drop_d got=%h exp=a5", d_o); end
      pop_byte();
      checks++; if (lsr_thre_o !== 1'b1) begin errors++; $display("FAIL hold_pop_lsr_thre got=%b exp=1", lsr_thre_o); end
      checks++; if (tx_thre_o !== 1'b1) begin errors++; $display("FAIL hold_pop_tx_thre got=%b exp=1", tx_thre_o); end
   endtask

   task automatic test_fifo_fill();
      logic [7:0] e;
      fifo_en_i = 1'b1;
      step();
      for (int i = 0; i <= 16; i++) wr_byte(8'(i));
      checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL fill_level got=%0d exp=16", level_o); end
      for (int i = 0; i < 16; i++) begin
         e = 8'(i);
         checks++; if (d_o !== e) begin errors++; $display("FAIL fill_order[%0d] got=%h exp=%h", i, d_o, e); end
         pop_byte();
      end
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL fill_drain_level got=%0d exp=0", level_o); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] e;
      for (int i = 0; i < 16; i++) wr_byte(8'h20 + 8'(i));
      thr_we_i = 1'b1; thr_d_i = 8'h77; pop_i = 1'b1;
      step();
      thr_we_i = 1'b0; pop_i = 1'b0;
      checks++; if (level_o !== 5'd16) begin errors++; $display("FAIL b2b_full_level got=%0d exp=16", level_o); end
      for (int i = 0; i < 15; i++) begin
         e = 8'h21 + 8'(i);
         checks++; if (d_o !== e) begin errors++; $display("FAIL b2b_order[%0d] got=%h exp=%h", i, d_o, e); end
         pop_byte();
      end
      checks++; if (d_o !== 8'h77) begin errors++; $display("FAIL b2b_appended got=%h exp=77", d_o); end
      pop_byte();
      thr_we_i = 1'b1; thr_d_i = 8'h55; pop_i = 1'b1;
      step();
      thr_we_i = 1'b0; pop_i = 1'b0;
      checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL b2b_empty_level got=%0d exp=1", level_o); end
      checks++; if (d_o !== 8'h55) begin errors++; $display("FAIL b2b_empty_d got=%h exp=55", d_o); end
      pop_byte();
   endtask

   task automatic test_interrupt();
      wr_byte(8'h11);
      wr_byte(8'h22);
      etbei_i = 1'b1;
      step();
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL irq_en_nonempty got=%b exp=0", thre_ip_o); end
      pop_byte();
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL irq_pop_2to1 got=%b exp=0", thre_ip_o); end
      pop_byte();
      checks++; if (thre_ip_o !== 1'b1) begin errors++; $display("FAIL irq_last_pop got=%b exp=1", thre_ip_o); end
      iir_rd_thre_i = 1'b1; step(); iir_rd_thre_i = 1'b0;
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL irq_iir_clear got=%b exp=0", thre_ip_o); end
      etbei_i = 1'b0; step();
      etbei_i = 1'b1; step();
      checks++; if (thre_ip_o !== 1'b1) begin errors++; $display("FAIL irq_etbei_rise got=%b exp=1", thre_ip_o); end
      thr_we_i = 1'b1; thr_d_i = 8'h33; iir_rd_thre_i = 1'b1;
      step();
      thr_we_i = 1'b0; iir_rd_thre_i = 1'b0;
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL irq_wr_iir got=%b exp=0", thre_ip_o); end
      checks++; if (level_o !== 5'd1) begin errors++; $display("FAIL irq_wr_level got=%0d exp=1", level_o); end
      pop_byte();
      checks++; if (thre_ip_o !== 1'b1) begin errors++; $display("FAIL irq_pop_again got=%b exp=1", thre_ip_o); end
      etbei_i = 1'b0; step();
      checks++; if (thre_ip_o !== 1'b0) begin errors++; $display("FAIL irq_disable got=%b exp=0", thre_ip_o); end
   endtask

   task automatic test_fifo_reset();
      for (int i = 0; i < 7; i++) wr_byte(8'h40 + 8'(i));
      checks++; if (level_o !== 5'd7) begin errors++; $display("FAIL frst_pre_level got=%0d exp=7", level_o); end
      sr_empty_i = 1'b0;
      step();
      checks++; if (lsr_temt_o !== 1'b0) begin errors++; $display("FAIL frst_temt_busy got=%b exp=0", lsr_temt_o); end
      tx_fifo_rst_i = 1'b1; thr_we_i = 1'b1; thr_d_i = 8'h99;
      step();
      tx_fifo_rst_i = 1'b0; thr_we_i = 1'b0;
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL frst_level got=%0d exp=0", level_o); end
      checks++; if (lsr_thre_o !== 1'b1) begin errors++; $display("FAIL frst_lsr_thre got=%b exp=1", lsr_thre_o); end
      checks++; if (tx_thre_o !== 1'b1) begin errors++; $display("FAIL frst_tx_thre got=%b exp=1", tx_thre_o); end
      checks++; if (lsr_temt_o !== 1'b0) begin errors++; $display("FAIL frst_temt_sr_busy got=%b exp=0", lsr_temt_o); end
      sr_empty_i = 1'b1;
      step();
      checks++; if (lsr_temt_o !== 1'b1) begin errors++; $display("FAIL frst_temt_idle got=%b exp=1", lsr_temt_o); end
      for (int i = 0; i < 3; i++) wr_byte(8'h50 + 8'(i));
      fifo_en_i = 1'b0; step();
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL mode_toggle_off got=%0d exp=0", level_o); end
      wr_byte(8'h61);
      fifo_en_i = 1'b1; step();
      checks++; if (level_o !== 5'd0) begin errors++; $display("FAIL mode_toggle_on got=%0d exp=0", level_o); end
   endtask

`ifdef UART16550_AUTO_CTS_EN
   task automatic test_auto_cts();
      afe_i = 1'b1; cts_ni = 1'b1;
      for (int i = 0; i < 3; i++) wr_byte(8'h70 + 8'(i));
      step();
      checks++; if (tx_thre_o !== 1'b1) begin errors++; $display("FAIL cts_hold got=%b exp=1", tx_thre_o); end
      cts_ni = 1'b0;
      step();
      checks++; if (tx_thre_o !== 1'b1) begin errors++; $display("FAIL cts_sync1 got=%b exp=1", tx_thre_o); end
      step();
      checks++; if (tx_thre_o !== 1'b0) begin errors++; $display("FAIL cts_release got=%b exp=0", tx_thre_o); end
      for (int i = 0; i < 3; i++) pop_byte();
      afe_i = 1'b0; cts_ni = 1'b1;
      step(); step();
   endtask
`endif

   initial begin
      test_reset();
      test_holding();
      test_fifo_fill();
      test_back_to_back();
      test_interrupt();
`ifdef UART16550_AUTO_CTS_EN
      test_auto_cts();
`endif
      test_fifo_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
